// File: rtl/bsdot_pkg.sv
// Shared types and width helpers for the bit-serial dot-product accumulator.
// Everything here is pure parameter math: no logic and no state.
package bsdot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // A single plane partial: the weight width plus room for LANES terms plus a sign bit.
  function automatic int pbits_f(input int lanes, input int wbits);
    return wbits + $clog2(lanes) + 1;
  endfunction

  // The dot product is shifted left once per plane after the first (ABITS-2 times in all).
  function automatic int dotw_f(input int lanes, input int wbits, input int abits);
    return pbits_f(lanes, wbits) + abits - 2;
  endfunction

  function automatic longint sat_max_f(input int obits);
    return (longint'(1) << (obits - 1)) - 1;
  endfunction

  function automatic longint sat_min_f(input int obits);
    return -(longint'(1) << (obits - 1));
  endfunction

endpackage

// File: rtl/bsdot_plane_sum.sv
// Combinational signed conditional-add tree over one activation bit-plane.
// Latency 0; no handshake. A lane adds +w or -w when its plane bit is set.
module bsdot_plane_sum
  import bsdot_pkg::*;
#(
  parameter int LANES = 32,
  parameter int WBITS = 4,
  parameter int PBITS = pbits_f(LANES, WBITS)
) (
  input  logic [LANES*WBITS-1:0] weight,
  input  logic [LANES-1:0]       sign,
  input  logic [LANES-1:0]       plane,
  output logic signed [PBITS-1:0] p
);

  logic signed [PBITS-1:0] w_ext;

  // Negation happens at PBITS, so the most negative weight negates exactly.
  always_comb begin
    p     = '0;
    w_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      w_ext = PBITS'($signed(weight[i*WBITS +: WBITS]));
      if (plane[i]) begin
        p = sign[i] ? (p - w_ext) : (p + w_ext);
      end
    end
  end

endmodule

// File: rtl/bsdot_acc.sv
// Bit-serial signed dot-product accumulator. Result is ready ABITS-1 cycles after accept; one vector every ABITS cycles.
// out_sum/out_valid are held while out_ready is low, with no new vector taken. BSDOT_SAT_EN selects a saturating accumulator (otherwise it wraps).
module bsdot_acc
  import bsdot_pkg::*;
#(
  parameter int LANES = 32,
  parameter int WBITS = 4,
  parameter int ABITS = 4,
  parameter int OBITS = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*WBITS-1:0] weight,
  input  logic [LANES*ABITS-1:0] activation,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OBITS-1:0]       out_sum
);

  localparam int M     = ABITS - 1;
  localparam int PBITS = pbits_f(LANES, WBITS);
  localparam int DW    = dotw_f(LANES, WBITS, ABITS);
  localparam int KW    = (M > 1) ? $clog2(M) : 1;

  state_t                  state, state_nxt;
  logic [LANES*WBITS-1:0]  w_q;
  logic [LANES*ABITS-1:0]  a_q;
  logic                    last_q;
  logic [KW-1:0]           k;
  logic signed [DW-1:0]    dot, dot_base, dot_nxt;
  logic signed [OBITS-1:0] acc, acc_nxt, v;
  logic [LANES-1:0]        sign_bits, plane_bits;
  logic [ABITS-1:0]        lane, lane_sh;
  logic signed [PBITS-1:0] p;

  always_comb begin
    sign_bits  = '0;
    plane_bits = '0;
    lane       = '0;
    lane_sh    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane          = a_q[i*ABITS +: ABITS];
      lane_sh       = lane >> k;
      sign_bits[i]  = lane[ABITS-1];
      plane_bits[i] = lane_sh[0];
    end
  end

  bsdot_plane_sum #(
    .LANES(LANES),
    .WBITS(WBITS),
    .PBITS(PBITS)
  ) u_plane_sum (
    .weight(w_q),
    .sign  (sign_bits),
    .plane (plane_bits),
    .p     (p)
  );

  // The first plane starts from zero rather than from the previous vector's dot.
  always_comb begin
    dot_base = (k == KW'(M - 1)) ? '0 : (dot <<< 1);
    dot_nxt  = dot_base + DW'(p);
    v        = OBITS'(dot_nxt);
  end

`ifdef BSDOT_SAT_EN
  localparam logic signed [OBITS-1:0] SAT_MAX = OBITS'(sat_max_f(OBITS));
  localparam logic signed [OBITS-1:0] SAT_MIN = OBITS'(sat_min_f(OBITS));
  logic [OBITS:0] sum_w;

  always_comb begin
    sum_w = {acc[OBITS-1], acc} + {v[OBITS-1], v};
    if (sum_w[OBITS] != sum_w[OBITS-1]) begin
      acc_nxt = sum_w[OBITS] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_nxt = sum_w[OBITS-1:0];
    end
  end
`else
  always_comb begin
    acc_nxt = acc + v;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (k == '0) state_nxt = last_q ? OUT : IDLE;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q     <= '0;
      a_q     <= '0;
      last_q  <= 1'b0;
      k       <= '0;
      dot     <= '0;
      acc     <= '0;
      out_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w_q    <= weight;
            a_q    <= activation;
            last_q <= in_last;
            k      <= KW'(M - 1);
          end
        end
        RUN: begin
          dot <= dot_nxt;
          k   <= k - KW'(1);
          if (k == '0) begin
            if (last_q) begin
              out_sum <= acc_nxt;
              acc     <= '0;
            end else begin
              acc <= acc_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsdot_acc.sv
// Bench for bsdot_acc: a 24-bit and a 12-bit accumulator run in lockstep on shared stimulus.
// The reference computes each dot product directly as the sum of w * signed activation.
module tb_bsdot_acc;

  localparam int LANES   = 32;
  localparam int WBITS   = 4;
  localparam int ABITS   = 4;
  localparam int OBITS   = 24;
  localparam int OBITS_S = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                       in_valid = 1'b0;
  logic                       in_last  = 1'b0;
  logic                       out_ready = 1'b0;
  logic [LANES*WBITS-1:0]     weight = '0;
  logic [LANES*ABITS-1:0]     activation = '0;
  logic                       in_ready, out_valid, in_ready_s, out_valid_s;
  logic signed [OBITS-1:0]    out_sum;
  logic signed [OBITS_S-1:0]  out_sum_s;

  bsdot_acc #(.LANES(LANES), .WBITS(WBITS), .ABITS(ABITS), .OBITS(OBITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .weight(weight), .activation(activation), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum)
  );

  bsdot_acc #(.LANES(LANES), .WBITS(WBITS), .ABITS(ABITS), .OBITS(OBITS_S)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .weight(weight), .activation(activation), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_sum(out_sum_s)
  );

  int     checks = 0;
  int     errors = 0;
  longint acc_ref = 0, acc_ref_s = 0, exp_sum = 0, exp_sum_s = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint x, input int bits);
    longint m, r;
    m = longint'(1) << bits;
    r = x & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint clamp(input longint x, input int bits);
    longint hi;
    hi = (longint'(1) << (bits - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi - 1;
    return x;
  endfunction

  function automatic longint dot_ref(input logic [LANES*WBITS-1:0] w, input logic [LANES*ABITS-1:0] a);
    longint s, term;
    logic signed [WBITS-1:0] wi;
    logic [ABITS-2:0] mag;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      wi   = w[i*WBITS +: WBITS];
      mag  = a[i*ABITS +: ABITS-1];
      term = longint'(wi) * longint'(mag);
      if (a[i*ABITS + ABITS - 1]) term = -term;
      s += term;
    end
    return s;
  endfunction

  function automatic logic [LANES*WBITS-1:0] rep_w(input logic [WBITS-1:0] x);
    logic [LANES*WBITS-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WBITS +: WBITS] = x;
    return r;
  endfunction

  function automatic logic [LANES*ABITS-1:0] rep_a(input logic [ABITS-1:0] x);
    logic [LANES*ABITS-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ABITS +: ABITS] = x;
    return r;
  endfunction

  task automatic send_vec(input logic [LANES*WBITS-1:0] w, input logic [LANES*ABITS-1:0] a, input logic last);
    longint v;
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    weight = w; activation = a; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    weight = {$urandom, $urandom, $urandom, $urandom};
    activation = {$urandom, $urandom, $urandom, $urandom};
    in_last = $urandom_range(0, 1);
    check("busy_after_accept", in_ready, 0);
    v = dot_ref(w, a);
    acc_ref = wrap(acc_ref + v, OBITS);
`ifdef BSDOT_SAT_EN
    acc_ref_s = clamp(acc_ref_s + v, OBITS_S);
`else
    acc_ref_s = wrap(acc_ref_s + v, OBITS_S);
`endif
    if (last) begin
      exp_sum = acc_ref; exp_sum_s = acc_ref_s;
      acc_ref = 0; acc_ref_s = 0;
    end
  endtask

  task automatic wait_result(input string tag, input int stall);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 3);
    check({tag, "_valid12"}, out_valid_s, 1);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_sum12"}, out_sum_s, exp_sum_s);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_sum"}, out_sum, exp_sum);
      check({tag, "_stall_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_ready"}, in_ready, 1);
  endtask

  logic [LANES*WBITS-1:0] w3;
  logic [LANES*ABITS-1:0] a3;
  int glen;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_sum12", out_sum_s, 0);
    rst = 1'b1;
    @(negedge clk);

    send_vec(rep_w(4'd1), rep_a(4'b0111), 1'b1);
    wait_result("pos_ones", 0);
    check("pos_ones_lit", out_sum, 224);

    send_vec(rep_w(4'b1000), rep_a(4'b1111), 1'b1);
    wait_result("neg_min", 0);
    check("neg_min_lit", out_sum, 1792);

    w3 = {$urandom, $urandom, $urandom, $urandom};
    a3 = '0;
    w3[0 +: 4] = 4'd3;    a3[0 +: 4] = 4'b0101;
    w3[4 +: 4] = 4'b1110; a3[4 +: 4] = 4'b1011;
    w3[8 +: 4] = 4'd7;    a3[8 +: 4] = 4'b1000;
    send_vec(w3, a3, 1'b1);
    wait_result("mixed", 0);
    check("mixed_lit", out_sum, 21);

    send_vec(rep_w(4'd1), rep_a(4'b0111), 1'b0);
    send_vec(rep_w(4'd1), rep_a(4'b0111), 1'b0);
    send_vec(rep_w(4'd1), rep_a(4'b0111), 1'b1);
    wait_result("group3", 5);
    check("group3_lit", out_sum, 672);

    send_vec(rep_w(4'b1000), rep_a(4'b1111), 1'b0);
    send_vec(rep_w(4'b1000), rep_a(4'b1111), 1'b1);
    wait_result("ovf", 0);
`ifdef BSDOT_SAT_EN
    check("ovf12_lit", out_sum_s, 2047);
`else
    check("ovf12_lit", out_sum_s, -512);
`endif
    check("ovf24_lit", out_sum, 3584);

    // Discard a partially accumulated group by resetting inside RUN.
    send_vec(rep_w(4'd1), rep_a(4'b0111), 1'b0);
    send_vec(rep_w(4'd5), rep_a(4'b0011), 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_ready", in_ready, 1);
    check("midrun_rst_ready12", in_ready_s, 1);
    check("midrun_rst_sum", out_sum, 0);
    acc_ref = 0; acc_ref_s = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_vec(rep_w(4'd1), rep_a(4'b0111), 1'b1);
    wait_result("after_rst", 0);
    check("after_rst_lit", out_sum, 224);

    for (int g = 0; g < 20; g++) begin
      glen = $urandom_range(1, 4);
      for (int j = 0; j < glen; j++) begin
        send_vec({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, j == glen - 1);
      end
      wait_result("rand", $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bsdot_acc.md
# bsdot_acc

Parametrised bit-serial signed dot-product accumulator for the activation/weight MAC datapath. Accepts one vector of LANES two's-complement weights and LANES sign-magnitude activations per handshake. It processes activation magnitude bit-planes MSB-first, one plane per cycle, and accumulates successive vectors until a vector tagged last. The final sum is then presented on a valid/ready output port.

## Interface
- LANES, 32, number of weight/activation lanes (≥2)
- WBITS, 4, weight width, two's complement
- ABITS, 4, activation width: bit ABITS-1 = sign, bits ABITS-2:0 = magnitude (≥2)
- OBITS, 24, accumulator/output width, two's complement
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input vector present
- in_ready  out  1  block can accept a vector
- in_last  in  1  vector closes the accumulation group
- weight  in  LANES*WBITS  lane i at [i*WBITS +: WBITS]
- activation  in  LANES*ABITS  lane i at [i*ABITS +: ABITS]
- out_valid  out  1  out_sum holds a finished group sum
- out_ready  in  1  downstream accepts out_sum
- out_sum  out  OBITS  accumulated signed dot product

## Operation
- M = ABITS-1 magnitude planes.
- PBITS = WBITS + clog2(LANES) + 1 is the per-plane partial width.
- Plane partial p(k) = Σ over lanes of: 0 if magnitude bit k is 0; otherwise -w if the sign bit is set, else +w.
  - The -w term is computed at PBITS width, so -(-2^(WBITS-1)) is exact.
- Negative zero (sign=1, magnitude=0) contributes 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, register weight, activation and in_last, and go to RUN with plane index k=M-1.
  - RUN: one plane per cycle. First plane: dot <= p(M-1). Later planes: dot <= (dot<<1) + p(k), arithmetic.
    - On plane 0, v = (dot<<1) + p(0), sign-extended to OBITS, and acc_next = acc + v.
    - If the latched last flag is set: out_sum <= acc_next, acc <= 0, go to OUT.
    - Otherwise: acc <= acc_next, go to IDLE.
  - OUT: out_valid=1, out_sum stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and OUT. Inputs are ignored while in_ready=0.
- dot is kept at full internal width PBITS+M-1, so it never overflows.
- acc arithmetic overflow is handled per Configuration.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, acc=0, dot=0, state=IDLE.
- Accept edge E0 is the edge where in_valid && in_ready. Planes are computed at edges E1..EM.
- out_valid is high from EM (latency M cycles; 3 for ABITS=4).
- Throughput: one vector per M+1 cycles with in_valid held high.
- The handshake completes on the edge where out_valid && out_ready. out_valid falls after that edge and in_ready rises in the same cycle.
- Back-pressure: out_sum and out_valid are held indefinitely while out_ready=0. No new vector is accepted during that time.
- Group length is unbounded. The accumulator is cleared only by a last vector or by reset.
- Reset at any time (including mid-RUN or OUT) discards the in-flight vector and the partial acc. Outputs return to reset values immediately (asynchronous).
- in_last on a single vector gives a one-vector group.

## Configuration
- BSDOT_SAT_EN defined: acc_next saturates to [-2^(OBITS-1), 2^(OBITS-1)-1].
  - Once saturated, acc stays clamped while further additions push in the same direction.
  - Additions of the opposite sign move it normally.
- BSDOT_SAT_EN undefined: acc_next wraps modulo 2^OBITS.

## Structure
- The package bsdot_pkg holds:
  - the state enum (IDLE, RUN, OUT);
  - the clog2-based width functions for PBITS and the dot width;
  - the saturation min/max constants as OBITS-parameterised functions.
- One sub-module, bsdot_plane_sum: combinational signed conditional-add tree.
  - Inputs: LANES weights, LANES sign bits, LANES plane bits.
  - Output: p at PBITS.
- The FSM, dot register and accumulator live in bsdot_acc.

## Test plan
All scenarios use default parameters unless stated.
- All weights +1, all activations +7 (0111), in_last=1 -> out_valid 3 cycles after accept, out_sum=224.
- All weights -8 (1000), all activations -7 (1111), last -> out_sum=1792. This covers the exact -(-8) case.
- Lane0 w=3, a=+5; lane1 w=-2, a=-3 (1011); lane2 w=7, a=1000 (negative zero); all other activations 0; last -> out_sum=21.
- Three +1/+7 vectors, in_last only on the third; out_ready held low 5 cycles -> exactly one output of 672. out_sum stable and in_ready=0 throughout the stall. in_ready=1 the cycle after the handshake.
- OBITS=12 instance, two all -8/-7 vectors, last on the second:
  - with BSDOT_SAT_EN -> out_sum=2047;
  - without BSDOT_SAT_EN -> out_sum=-512.
- rst asserted during the second RUN cycle:
  - out_valid=0 and in_ready=1 immediately;
  - after release, a single +1/+7 last vector -> 224, with no residue from the discarded vector.
